multi_phase_traffic_controller: RTL and testbench

Parametrised N-approach traffic light controller, successor to the 2-way controller. It serves NUM_DIRS approaches in round-robin order. Optional demand skipping and gap-out shorten or skip phases with no traffic. Emergency preemption always passes through yellow and all-red, and emergency green is held while the request persists. It sits between the debounced sensor/emergency inputs and the lamp drivers.

---
 rtl/multi_phase_traffic_controller.sv | 187 ++++++++++++++++++
 tb/tb_multi_phase_traffic_controller.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_phase_traffic_controller.sv
// -----------------------------------------------------------------------------
// multi_phase_traffic_controller
//
// Round-robin traffic light controller for NUM_DIRS approaches. Each approach
// is served by a green phase followed by yellow and an all-red clearance.
// With SKIP_EMPTY set, directions without demand are skipped and a green with
// no local traffic ends early (gap-out) once its minimum length has elapsed.
// With no competing traffic the green rests. Emergency requests preempt the
// current green. The controller always passes through yellow and all-red
// before serving an emergency on another approach. Emergency green is held for
// as long as the request on that approach persists.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   demand       per-direction vehicle presence (synchronous level)
//   emg_req      per-direction emergency request (synchronous level)
//   red          per-direction red lamp
//   yellow       per-direction yellow lamp
//   green        per-direction green lamp
//   active_dir   direction currently served
//   emg_active   high while an emergency green is shown
//   state_debug  state encoding: 0 green, 1 yellow, 2 all-red, 3 emergency green
// -----------------------------------------------------------------------------
module multi_phase_traffic_controller #(
   parameter int NUM_DIRS        = 4,
   parameter int COUNTER_WIDTH   = 32,
   parameter int GREEN_TICKS     = 50000000,
   parameter int MIN_GREEN_TICKS = 10000000,
   parameter int YELLOW_TICKS    = 5000000,
   parameter int ALLRED_TICKS    = 1000000,
   parameter int EMG_GREEN_TICKS = 80000000,
   parameter int SKIP_EMPTY      = 1,
   localparam int DIR_W          = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_DIRS-1:0] demand,
   input  logic [NUM_DIRS-1:0] emg_req,
   output logic [NUM_DIRS-1:0] red,
   output logic [NUM_DIRS-1:0] yellow,
   output logic [NUM_DIRS-1:0] green,
   output logic [DIR_W-1:0]    active_dir,
   output logic                emg_active,
   output logic [1:0]          state_debug
);

   typedef enum logic [1:0] {
      S_GREEN     = 2'd0,
      S_YELLOW    = 2'd1,
      S_ALLRED    = 2'd2,
      S_EMG_GREEN = 2'd3
   } state_t;

   // Terminal timer values: a phase of length X ends when the timer reads X-1.
   localparam logic [COUNTER_WIDTH-1:0] GREEN_LAST  = COUNTER_WIDTH'(GREEN_TICKS - 1);
   localparam logic [COUNTER_WIDTH-1:0] MIN_LAST    = COUNTER_WIDTH'(MIN_GREEN_TICKS - 1);
   localparam logic [COUNTER_WIDTH-1:0] YELLOW_LAST = COUNTER_WIDTH'(YELLOW_TICKS - 1);
   localparam logic [COUNTER_WIDTH-1:0] ALLRED_LAST = COUNTER_WIDTH'(ALLRED_TICKS - 1);
   localparam logic [COUNTER_WIDTH-1:0] EMG_LAST    = COUNTER_WIDTH'(EMG_GREEN_TICKS - 1);
   localparam bit                       SKIP        = (SKIP_EMPTY != 0);

   state_t                   state;
   logic [COUNTER_WIDTH-1:0] timer;
   logic [DIR_W-1:0]         cur_dir;
   logic [DIR_W-1:0]         tgt_dir;
   logic                     tgt_emg;
   // Set only during the clearance that follows reset, so that the first
   // normal green always goes to direction 0.
   logic                     boot;

   logic [NUM_DIRS-1:0]      cur_onehot;
   logic                     other_demand;
   logic [DIR_W-1:0]         pick_dir;
   logic                     pick_emg;

   assign cur_onehot   = NUM_DIRS'(1) << cur_dir;
   assign other_demand = |(demand & ~cur_onehot);

   // Next direction to serve. The loops run from the far end toward the
   // preferred end so that the last hit (lowest emergency index, or nearest
   // demanding direction after cur_dir) is the one that sticks.
   always_comb begin
      pick_dir = DIR_W'((int'(cur_dir) + 1) % NUM_DIRS);
      pick_emg = 1'b0;
      if (|emg_req) begin
         pick_emg = 1'b1;
         for (int d = NUM_DIRS - 1; d >= 0; d--) begin
            if (emg_req[d]) pick_dir = DIR_W'(d);
         end
      end else if (SKIP) begin
         for (int k = NUM_DIRS; k >= 1; k--) begin
            if (demand[DIR_W'((int'(cur_dir) + k) % NUM_DIRS)])
               pick_dir = DIR_W'((int'(cur_dir) + k) % NUM_DIRS);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_ALLRED;
         timer   <= '0;
         cur_dir <= '0;
         tgt_dir <= '0;
         tgt_emg <= 1'b0;
         boot    <= 1'b1;
      end else begin
         case (state)
            S_GREEN: begin
               if (emg_req[cur_dir]) begin
                  // Emergency on the approach already green: no lamp change.
                  state <= S_EMG_GREEN;
                  timer <= '0;
               end else if (|emg_req) begin
                  // Preemption ignores the minimum green.
                  state <= S_YELLOW;
                  timer <= '0;
               end else if (SKIP && timer >= MIN_LAST && !demand[cur_dir] && other_demand) begin
                  state <= S_YELLOW;
                  timer <= '0;
               end else if (timer == GREEN_LAST) begin
                  // Rest in green (timer saturated) while nobody else waits.
                  if (!(SKIP && !other_demand)) begin
                     state <= S_YELLOW;
                     timer <= '0;
                  end
               end else begin
                  timer <= timer + COUNTER_WIDTH'(1);
               end
            end

            S_YELLOW: begin
               tgt_dir <= pick_dir;
               tgt_emg <= pick_emg;
               if (timer == YELLOW_LAST) begin
                  state <= S_ALLRED;
                  timer <= '0;
               end else begin
                  timer <= timer + COUNTER_WIDTH'(1);
               end
            end

            S_ALLRED: begin
               if (boot && !pick_emg) begin
                  tgt_dir <= '0;
                  tgt_emg <= 1'b0;
               end else begin
                  tgt_dir <= pick_dir;
                  tgt_emg <= pick_emg;
               end
               if (timer == ALLRED_LAST) begin
                  cur_dir <= tgt_dir;
                  state   <= tgt_emg ? S_EMG_GREEN : S_GREEN;
                  timer   <= '0;
                  boot    <= 1'b0;
               end else begin
                  timer <= timer + COUNTER_WIDTH'(1);
               end
            end

            S_EMG_GREEN: begin
               if (timer >= EMG_LAST && !emg_req[cur_dir]) begin
                  state <= S_YELLOW;
                  timer <= '0;
               end else if (timer < EMG_LAST) begin
                  timer <= timer + COUNTER_WIDTH'(1);
               end
            end

            default: begin
               state <= S_ALLRED;
               timer <= '0;
            end
         endcase
      end
   end

   // Lamps decode straight from the registered state so an asynchronous reset
   // shows all-red without waiting for a clock edge.
   assign green       = (state == S_GREEN || state == S_EMG_GREEN) ? cur_onehot : '0;
   assign yellow      = (state == S_YELLOW) ? cur_onehot : '0;
   assign red         = ~(green | yellow);
   assign active_dir  = cur_dir;
   assign emg_active  = (state == S_EMG_GREEN);
   assign state_debug = state;

endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
module tb_multi_phase_traffic_controller;

   localparam int N  = 4;
   localparam int GT = 8;
   localparam int MT = 4;
   localparam int YT = 3;
   localparam int AT = 2;
   localparam int ET = 6;

   // Phase kinds, numbered as the state_debug output reports them.
   localparam int K_G = 0;
   localparam int K_Y = 1;
   localparam int K_R = 2;
   localparam int K_E = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] demand = '0;
   logic [N-1:0] emg_req = '0;

   logic [N-1:0] red0, yel0, grn0, red1, yel1, grn1;
   logic [1:0]   dir0, dir1, sd0, sd1;
   logic         ea0, ea1;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   multi_phase_traffic_controller #(
      .NUM_DIRS(N), .COUNTER_WIDTH(16), .GREEN_TICKS(GT), .MIN_GREEN_TICKS(MT),
      .YELLOW_TICKS(YT), .ALLRED_TICKS(AT), .EMG_GREEN_TICKS(ET), .SKIP_EMPTY(0)
   ) dut_fixed (
      .clk(clk), .rst_n(rst_n), .demand(demand), .emg_req(emg_req),
      .red(red0), .yellow(yel0), .green(grn0), .active_dir(dir0),
      .emg_active(ea0), .state_debug(sd0)
   );

   multi_phase_traffic_controller #(
      .NUM_DIRS(N), .COUNTER_WIDTH(16), .GREEN_TICKS(GT), .MIN_GREEN_TICKS(MT),
      .YELLOW_TICKS(YT), .ALLRED_TICKS(AT), .EMG_GREEN_TICKS(ET), .SKIP_EMPTY(1)
   ) dut_skip (
      .clk(clk), .rst_n(rst_n), .demand(demand), .emg_req(emg_req),
      .red(red1), .yellow(yel1), .green(grn1), .active_dir(dir1),
      .emg_active(ea1), .state_debug(sd1)
   );

   // Reference model: one entry per instance (0 = fixed, 1 = skipping).
   // age counts the cycles already spent in the current phase, starting at 1.
   int m_ph[2], m_age[2], m_dir[2], m_tdir[2];
   bit m_temg[2], m_boot[2];

   typedef struct {
      int           kind;
      int           dir;
      int           len;
      logic [N-1:0] dem;
      logic [N-1:0] emg;
   } seg_t;

   function automatic seg_t mk(int kind, int dir, int len, logic [N-1:0] dem, logic [N-1:0] emg);
      seg_t s;
      s.kind = kind; s.dir = dir; s.len = len; s.dem = dem; s.emg = emg;
      return s;
   endfunction

   // Full output word {red, yellow, green, active_dir, emg_active, state_debug}.
   function automatic logic [16:0] kind_word(int kind, int dir);
      logic [N-1:0] oh, g, y;
      oh = 4'b0001 << dir;
      g  = (kind == K_G || kind == K_E) ? oh : 4'b0000;
      y  = (kind == K_Y) ? oh : 4'b0000;
      return {~(g | y), y, g, 2'(dir), (kind == K_E), 2'(kind)};
   endfunction

   function automatic logic [16:0] obs(int i);
      if (i == 0) return {red0, yel0, grn0, dir0, ea0, sd0};
      return {red1, yel1, grn1, dir1, ea1, sd1};
   endfunction

   function automatic logic [16:0] model_word(int i);
      return kind_word(m_ph[i], m_dir[i]);
   endfunction

   task automatic model_reset(int i);
      m_ph[i] = K_R; m_age[i] = 1; m_dir[i] = 0;
      m_tdir[i] = 0; m_temg[i] = 1'b0; m_boot[i] = 1'b1;
   endtask

   task automatic model_step(int i);
      int  d, p_dir, old_tdir;
      bit  p_emg, oth, skip, found, old_temg, old_boot;
      d    = m_dir[i];
      skip = (i == 1);
      oth  = 1'b0;
      for (int k = 0; k < N; k++) if (k != d && demand[k]) oth = 1'b1;
      // Choice of the next approach from the request rules.
      p_emg = (emg_req != 0);
      p_dir = (d + 1) % N;
      found = 1'b0;
      if (p_emg) begin
         for (int k = 0; k < N; k++)
            if (!found && emg_req[k]) begin p_dir = k; found = 1'b1; end
      end else if (skip) begin
         for (int k = 1; k <= N; k++)
            if (!found && demand[(d + k) % N]) begin p_dir = (d + k) % N; found = 1'b1; end
      end
      case (m_ph[i])
         K_G: begin
            if (emg_req[d]) begin m_ph[i] = K_E; m_age[i] = 1; end
            else if (emg_req != 0) begin m_ph[i] = K_Y; m_age[i] = 1; end
            else if (skip && m_age[i] >= MT && !demand[d] && oth) begin m_ph[i] = K_Y; m_age[i] = 1; end
            else if (m_age[i] >= GT) begin
               if (!(skip && !oth)) begin m_ph[i] = K_Y; m_age[i] = 1; end
            end else m_age[i]++;
         end
         K_Y: begin
            m_tdir[i] = p_dir; m_temg[i] = p_emg;
            if (m_age[i] >= YT) begin m_ph[i] = K_R; m_age[i] = 1; end
            else m_age[i]++;
         end
         K_R: begin
            old_tdir = m_tdir[i]; old_temg = m_temg[i]; old_boot = m_boot[i];
            if (old_boot && !p_emg) begin m_tdir[i] = 0; m_temg[i] = 1'b0; end
            else begin m_tdir[i] = p_dir; m_temg[i] = p_emg; end
            if (m_age[i] >= AT) begin
               m_dir[i] = old_tdir; m_ph[i] = old_temg ? K_E : K_G;
               m_age[i] = 1; m_boot[i] = 1'b0;
            end else m_age[i]++;
         end
         default: begin
            if (!emg_req[d] && m_age[i] >= ET) begin m_ph[i] = K_Y; m_age[i] = 1; end
            else if (m_age[i] < ET) m_age[i]++;
         end
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (rst_n) model_step(i);
         else model_reset(i);
      end
      #1;
   endtask

   task automatic do_reset();
      demand = '0; emg_req = '0; rst_n = 1'b0;
      model_reset(0); model_reset(1);
      tick(); tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         total++;
         if (obs(i) !== kind_word(K_R, 0)) begin
            bad++;
            $display("FAIL reset_state inst=%0d got=%h want=%h", i, obs(i), kind_word(K_R, 0));
         end
      end
   endtask

   task automatic test_round_robin();
      seg_t q[$];
      do_reset();
      q.push_back(mk(K_R, 0, AT, 4'h0, 4'h0));
      for (int k = 0; k <= N; k++) begin
         q.push_back(mk(K_G, k % N, GT, 4'h0, 4'h0));
         q.push_back(mk(K_Y, k % N, YT, 4'h0, 4'h0));
         q.push_back(mk(K_R, k % N, AT, 4'h0, 4'h0));
      end
      for (int s = 0; s < q.size(); s++)
         for (int c = 0; c < q[s].len; c++) begin
            demand = q[s].dem; emg_req = q[s].emg;
            total++;
            if (obs(0) !== kind_word(q[s].kind, q[s].dir)) begin
               bad++;
               $display("FAIL round_robin seg=%0d cyc=%0d got=%h want=%h", s, c, obs(0), kind_word(q[s].kind, q[s].dir));
            end
            tick();
         end
   endtask

   task automatic test_skip_rest();
      seg_t q[$];
      do_reset();
      q.push_back(mk(K_R, 0, AT, 4'b0100, 4'h0));
      q.push_back(mk(K_G, 0, MT, 4'b0100, 4'h0));
      q.push_back(mk(K_Y, 0, YT, 4'b0100, 4'h0));
      q.push_back(mk(K_R, 0, AT, 4'b0100, 4'h0));
      q.push_back(mk(K_G, 2, GT, 4'b0100, 4'h0));
      q.push_back(mk(K_G, 2, 20, 4'b0000, 4'h0));
      q.push_back(mk(K_G, 2, 1, 4'b0001, 4'h0));
      q.push_back(mk(K_Y, 2, 1, 4'b0001, 4'h0));
      for (int s = 0; s < q.size(); s++)
         for (int c = 0; c < q[s].len; c++) begin
            demand = q[s].dem; emg_req = q[s].emg;
            total++;
            if (obs(1) !== kind_word(q[s].kind, q[s].dir)) begin
               bad++;
               $display("FAIL skip_rest seg=%0d cyc=%0d got=%h want=%h", s, c, obs(1), kind_word(q[s].kind, q[s].dir));
            end
            tick();
         end
   endtask

   task automatic test_preempt();
      seg_t q[$];
      do_reset();
      q.push_back(mk(K_R, 0, AT, 4'h0, 4'h0));
      q.push_back(mk(K_G, 0, GT, 4'h0, 4'h0));
      q.push_back(mk(K_Y, 0, YT, 4'h0, 4'h0));
      q.push_back(mk(K_R, 0, AT, 4'h0, 4'h0));
      q.push_back(mk(K_G, 1, 1, 4'h0, 4'h0));
      q.push_back(mk(K_G, 1, 1, 4'h0, 4'b1001));
      q.push_back(mk(K_Y, 1, YT, 4'h0, 4'b1001));
      q.push_back(mk(K_R, 1, AT, 4'h0, 4'b1001));
      q.push_back(mk(K_E, 0, 10, 4'h0, 4'b1001));
      q.push_back(mk(K_E, 0, 1, 4'h0, 4'b1000));
      q.push_back(mk(K_Y, 0, YT, 4'h0, 4'b1000));
      q.push_back(mk(K_R, 0, AT, 4'h0, 4'b1000));
      q.push_back(mk(K_E, 3, ET, 4'h0, 4'b0000));
      q.push_back(mk(K_Y, 3, 1, 4'h0, 4'b0000));
      for (int s = 0; s < q.size(); s++)
         for (int c = 0; c < q[s].len; c++) begin
            demand = q[s].dem; emg_req = q[s].emg;
            total++;
            if (obs(0) !== kind_word(q[s].kind, q[s].dir)) begin
               bad++;
               $display("FAIL preempt seg=%0d cyc=%0d got=%h want=%h", s, c, obs(0), kind_word(q[s].kind, q[s].dir));
            end
            tick();
         end
   endtask

   task automatic test_emg_same_dir();
      seg_t q[$];
      do_reset();
      q.push_back(mk(K_R, 0, AT, 4'h0, 4'h0));
      q.push_back(mk(K_G, 0, GT, 4'h0, 4'h0));
      q.push_back(mk(K_Y, 0, YT, 4'h0, 4'h0));
      q.push_back(mk(K_R, 0, AT, 4'h0, 4'h0));
      q.push_back(mk(K_G, 1, GT, 4'h0, 4'h0));
      q.push_back(mk(K_Y, 1, YT, 4'h0, 4'h0));
      q.push_back(mk(K_R, 1, AT, 4'h0, 4'h0));
      q.push_back(mk(K_G, 2, 2, 4'h0, 4'h0));
      q.push_back(mk(K_G, 2, 1, 4'h0, 4'b0100));
      q.push_back(mk(K_E, 2, 3, 4'h0, 4'b0100));
      q.push_back(mk(K_E, 2, ET - 3, 4'h0, 4'b0000));
      q.push_back(mk(K_Y, 2, YT, 4'h0, 4'b0000));
      q.push_back(mk(K_R, 2, AT, 4'h0, 4'b0000));
      q.push_back(mk(K_G, 3, 1, 4'h0, 4'b0000));
      for (int s = 0; s < q.size(); s++)
         for (int c = 0; c < q[s].len; c++) begin
            demand = q[s].dem; emg_req = q[s].emg;
            total++;
            if (obs(0) !== kind_word(q[s].kind, q[s].dir)) begin
               bad++;
               $display("FAIL emg_same_dir seg=%0d cyc=%0d got=%h want=%h", s, c, obs(0), kind_word(q[s].kind, q[s].dir));
            end
            tick();
         end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int c = 0; c < AT + GT + 1; c++) tick();
      #3;
      total++;
      if (yel0 !== 4'b0001) begin
         bad++;
         $display("FAIL async_pre_yellow got=%b want=%b", yel0, 4'b0001);
      end
      rst_n = 1'b0;
      model_reset(0); model_reset(1);
      #1;
      for (int i = 0; i < 2; i++) begin
         total++;
         if (obs(i) !== kind_word(K_R, 0)) begin
            bad++;
            $display("FAIL async_reset inst=%0d got=%h want=%h", i, obs(i), kind_word(K_R, 0));
         end
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      int  ar_cnt[2];
      bit  after_y[2];
      logic [N-1:0] g, y, r;
      do_reset();
      ar_cnt = '{0, 0};
      after_y = '{1'b0, 1'b0};
      for (int c = 0; c < 6000; c++) begin
         if ($urandom_range(5) == 0) demand = 4'($urandom());
         if ($urandom_range(15) == 0) emg_req = 4'($urandom() & $urandom() & $urandom());
         for (int i = 0; i < 2; i++) begin
            total++;
            if (obs(i) !== model_word(i)) begin
               bad++;
               $display("FAIL random_model inst=%0d cyc=%0d got=%h want=%h", i, c, obs(i), model_word(i));
            end
            r = (i == 0) ? red0 : red1;
            y = (i == 0) ? yel0 : yel1;
            g = (i == 0) ? grn0 : grn1;
            total++;
            if (!$onehot0(g | y) || r !== ~(g | y)) begin
               bad++;
               $display("FAIL lamp_safety inst=%0d cyc=%0d red=%b yellow=%b green=%b", i, c, r, y, g);
            end
            if (y != 0) begin
               after_y[i] = 1'b1; ar_cnt[i] = 0;
            end else if (g == 0) begin
               if (after_y[i]) ar_cnt[i]++;
            end else if (after_y[i]) begin
               total++;
               if (ar_cnt[i] != AT) begin
                  bad++;
                  $display("FAIL allred_len inst=%0d cyc=%0d got=%0d want=%0d", i, c, ar_cnt[i], AT);
               end
               after_y[i] = 1'b0;
            end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_skip_rest();
      test_preempt();
      test_emg_same_dir();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
